// File: rtl/sprite_motion_ctrl.sv
// sprite_motion_ctrl: per-frame motion sequencer for the square sprite.
// Key requests are OR-accumulated across a frame and applied at the frame
// strobe through IDLE -> LATCH -> MOVE_X -> MOVE_Y -> DONE. Speed ramps while a
// direction is held; after a long key-free period the sprite bounces on its own.
// Optional build macro: SPRITE_WRAP_EN -- manual moves that would clamp at an
// edge wrap to the opposite edge instead (auto bounce is unaffected).
module sprite_motion_ctrl #(
   parameter int CORDW       = 10,
   parameter int H_RES       = 640,
   parameter int V_RES       = 480,
   parameter int Q_SIZE      = 20,
   parameter int SPEED_MIN   = 1,
   parameter int SPEED_MAX   = 4,
   parameter int RAMP_FRAMES = 8,
   parameter int IDLE_FRAMES = 120
) (
   input  logic             clk_pix,
   input  logic             rst_pix,
   input  logic             frame,
   input  logic             key_up,
   input  logic             key_down,
   input  logic             key_left,
   input  logic             key_right,
   output logic [CORDW-1:0] qx,
   output logic [CORDW-1:0] qy,
   output logic [2:0]       speed,
   output logic             auto_mode,
   output logic             upd_done,
   output logic             overrun
);

   localparam int HOLD_MAX = (SPEED_MAX - SPEED_MIN) * RAMP_FRAMES;
   localparam int HW       = $clog2(HOLD_MAX + 2);
   localparam int IW       = $clog2(IDLE_FRAMES + 2);

   localparam logic [CORDW:0]   X_LIM  = (CORDW+1)'(H_RES - Q_SIZE);
   localparam logic [CORDW:0]   Y_LIM  = (CORDW+1)'(V_RES - Q_SIZE);
   localparam logic [CORDW-1:0] X_INIT = CORDW'((H_RES - Q_SIZE) / 2);
   localparam logic [CORDW-1:0] Y_INIT = CORDW'((V_RES - Q_SIZE) / 2);
   localparam logic [2:0]       SPD_MIN = 3'(SPEED_MIN);
   localparam logic [HW-1:0]    HOLD_SAT = HW'(HOLD_MAX);
   localparam logic [IW-1:0]    IDLE_SAT = IW'(IDLE_FRAMES);

`ifdef SPRITE_WRAP_EN
   localparam logic MANUAL_WRAP = 1'b1;
`else
   localparam logic MANUAL_WRAP = 1'b0;
`endif

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LATCH  = 3'd1;
   localparam logic [2:0] S_MOVE_X = 3'd2;
   localparam logic [2:0] S_MOVE_Y = 3'd3;
   localparam logic [2:0] S_DONE   = 3'd4;

   // Key bit order everywhere: [3]=up [2]=down [1]=left [0]=right
   logic [3:0]       cur_keys;
   logic [2:0]       state_q, state_d;
   logic [3:0]       latch_q, latch_d;
   logic [3:0]       snap_q, snap_d;
   logic [HW-1:0]    hold_q, hold_d;
   logic [IW-1:0]    idle_q, idle_d;
   logic [CORDW-1:0] qx_q, qx_d, qy_q, qy_d;
   logic [2:0]       speed_q, speed_d;
   logic             auto_q, auto_d;
   logic             dir_x_q, dir_x_d, dir_y_q, dir_y_d;
   logic             upd_done_q, upd_done_d;
   logic             overrun_q, overrun_d;
   logic [CORDW:0]   x_res, y_res;
   logic             any_act;

   assign cur_keys = {key_up, key_down, key_left, key_right};

   // Ramp speed from the hold count seen at the start of this frame.
   function automatic logic [2:0] ramp_speed(input logic [HW-1:0] h);
      int unsigned s;
      s = 32'(SPEED_MIN) + (32'(h) / 32'(RAMP_FRAMES));
      if (s > 32'(SPEED_MAX)) s = 32'(SPEED_MAX);
      return s[2:0];
   endfunction

   // One-axis step at CORDW+1 bits; returns {limit_hit, new_position}.
   // fwd=1 moves towards lim, fwd=0 towards 0. On a limit hit the position
   // clamps, or wraps to the opposite limit when wrap=1.
   function automatic logic [CORDW:0] axis_step(input logic [CORDW-1:0] pos,
                                               input logic [2:0]       spd,
                                               input logic [CORDW:0]   lim,
                                               input logic             fwd,
                                               input logic             wrap);
      logic [CORDW:0] p, s, r;
      logic           hit;
      p = {1'b0, pos};
      s = {{(CORDW-2){1'b0}}, spd};
      if (fwd) begin
         if (p + s <= lim) begin
            r   = p + s;
            hit = 1'b0;
         end else begin
            r   = wrap ? '0 : lim;
            hit = 1'b1;
         end
      end else begin
         if (p >= s) begin
            r   = p - s;
            hit = 1'b0;
         end else begin
            r   = wrap ? lim : '0;
            hit = 1'b1;
         end
      end
      return {hit, r[CORDW-1:0]};
   endfunction

   // Next-state logic: key accumulation, overrun detection and the update FSM.
   always_comb begin
      state_d    = state_q;
      snap_d     = snap_q;
      hold_d     = hold_q;
      idle_d     = idle_q;
      qx_d       = qx_q;
      qy_d       = qy_q;
      speed_d    = speed_q;
      auto_d     = auto_q;
      dir_x_d    = dir_x_q;
      dir_y_d    = dir_y_q;
      x_res      = {1'b0, qx_q};
      y_res      = {1'b0, qy_q};
      any_act    = (latch_q[0] ^ latch_q[1]) | (latch_q[2] ^ latch_q[3]);
      // Keys seen during LATCH belong to the next frame, so the latch restarts from them.
      latch_d    = (state_q == S_LATCH) ? cur_keys : (latch_q | cur_keys);
      overrun_d  = overrun_q | (frame & (state_q != S_IDLE));
      upd_done_d = (state_q == S_MOVE_Y);

      case (state_q)
         S_IDLE: begin
            if (frame) state_d = S_LATCH;
         end
         S_LATCH: begin
            snap_d = latch_q;
            if (any_act) begin
               hold_d  = (hold_q == HOLD_SAT) ? hold_q : hold_q + 1'b1;
               idle_d  = '0;
               auto_d  = 1'b0;
               speed_d = ramp_speed(hold_q);
            end else begin
               hold_d  = '0;
               idle_d  = (idle_q == IDLE_SAT) ? idle_q : idle_q + 1'b1;
               if (idle_d == IDLE_SAT) auto_d = 1'b1;
               speed_d = SPD_MIN;
            end
            state_d = S_MOVE_X;
         end
         S_MOVE_X: begin
            if (auto_q) begin
               x_res = axis_step(qx_q, SPD_MIN, X_LIM, dir_x_q, 1'b0);
               qx_d  = x_res[CORDW-1:0];
               if (x_res[CORDW]) dir_x_d = ~dir_x_q;
            end else if (snap_q[0] ^ snap_q[1]) begin
               x_res = axis_step(qx_q, speed_q, X_LIM, snap_q[0], MANUAL_WRAP);
               qx_d  = x_res[CORDW-1:0];
            end
            state_d = S_MOVE_Y;
         end
         S_MOVE_Y: begin
            if (auto_q) begin
               y_res = axis_step(qy_q, SPD_MIN, Y_LIM, dir_y_q, 1'b0);
               qy_d  = y_res[CORDW-1:0];
               if (y_res[CORDW]) dir_y_d = ~dir_y_q;
            end else if (snap_q[2] ^ snap_q[3]) begin
               y_res = axis_step(qy_q, speed_q, Y_LIM, snap_q[2], MANUAL_WRAP);
               qy_d  = y_res[CORDW-1:0];
            end
            state_d = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State registers; reset restores the centred sprite and aborts any update.
   always_ff @(posedge clk_pix or posedge rst_pix) begin
      if (rst_pix) begin
         state_q    <= S_IDLE;
         latch_q    <= '0;
         snap_q     <= '0;
         hold_q     <= '0;
         idle_q     <= '0;
         qx_q       <= X_INIT;
         qy_q       <= Y_INIT;
         speed_q    <= SPD_MIN;
         auto_q     <= 1'b0;
         dir_x_q    <= 1'b1;
         dir_y_q    <= 1'b1;
         upd_done_q <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         latch_q    <= latch_d;
         snap_q     <= snap_d;
         hold_q     <= hold_d;
         idle_q     <= idle_d;
         qx_q       <= qx_d;
         qy_q       <= qy_d;
         speed_q    <= speed_d;
         auto_q     <= auto_d;
         dir_x_q    <= dir_x_d;
         dir_y_q    <= dir_y_d;
         upd_done_q <= upd_done_d;
         overrun_q  <= overrun_d;
      end
   end

   assign qx        = qx_q;
   assign qy        = qy_q;
   assign speed     = speed_q;
   assign auto_mode = auto_q;
   assign upd_done  = upd_done_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Directed bench for sprite_motion_ctrl with hand-computed expectations.
module tb_sprite_motion_ctrl;

   logic       clk_pix = 1'b0;
   logic       rst_pix = 1'b0;
   logic       frame = 1'b0;
   logic       key_up = 1'b0, key_down = 1'b0, key_left = 1'b0, key_right = 1'b0;
   logic [9:0] qx, qy;
   logic [2:0] speed;
   logic       auto_mode, upd_done, overrun;

   int total = 0;
   int bad   = 0;
   int upd_cnt;

   localparam logic [3:0] K_NONE  = 4'b0000;
   localparam logic [3:0] K_RIGHT = 4'b0001;
   localparam logic [3:0] K_LEFT  = 4'b0010;
   localparam logic [3:0] K_UP    = 4'b1000;
   localparam logic [3:0] K_LR    = 4'b0011;

   sprite_motion_ctrl dut (
      .clk_pix   (clk_pix),
      .rst_pix   (rst_pix),
      .frame     (frame),
      .key_up    (key_up),
      .key_down  (key_down),
      .key_left  (key_left),
      .key_right (key_right),
      .qx        (qx),
      .qy        (qy),
      .speed     (speed),
      .auto_mode (auto_mode),
      .upd_done  (upd_done),
      .overrun   (overrun)
   );

   always #5 clk_pix = ~clk_pix;

   task automatic tick();
      @(posedge clk_pix);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic set_keys(input logic [3:0] k);
      {key_up, key_down, key_left, key_right} = k;
   endtask

   // Pulse keys for one cycle, then one frame strobe, then wait out the update.
   task automatic run_frame(input logic [3:0] k);
      set_keys(k);
      tick();
      set_keys(K_NONE);
      frame = 1'b1;
      tick();
      frame = 1'b0;
      repeat (5) tick();
   endtask

   initial begin
      // Reset state
      #3 rst_pix = 1'b1;
      #2;
      chk("rst_qx", 32'(qx), 310);
      chk("rst_qy", 32'(qy), 230);
      chk("rst_speed", 32'(speed), 1);
      chk("rst_auto", 32'(auto_mode), 0);
      chk("rst_upd", 32'(upd_done), 0);
      chk("rst_overrun", 32'(overrun), 0);
      tick();
      rst_pix = 1'b0;
      tick();

      // Latency of a key-free frame (idle count becomes 1)
      frame = 1'b1;
      tick();                       // t+1
      frame = 1'b0;
      chk("lat_upd_t1", 32'(upd_done), 0);
      tick();                       // t+2
      tick();                       // t+3
      chk("lat_upd_t3", 32'(upd_done), 0);
      chk("lat_qx_t3", 32'(qx), 310);
      tick();                       // t+4
      chk("lat_upd_t4", 32'(upd_done), 1);
      chk("lat_qy_t4", 32'(qy), 230);
      chk("lat_speed", 32'(speed), 1);
      tick();                       // t+5
      chk("lat_upd_t5", 32'(upd_done), 0);
      repeat (2) tick();

      // Ramp: 8 frames at 1, 8 at 2, then 3
      run_frame(K_RIGHT);
      chk("ramp_f1_speed", 32'(speed), 1);
      chk("ramp_f1_qx", 32'(qx), 311);
      repeat (8) run_frame(K_RIGHT);
      chk("ramp_f9_speed", 32'(speed), 2);
      chk("ramp_f9_qx", 32'(qx), 320);
      repeat (8) run_frame(K_RIGHT);
      chk("ramp_f17_speed", 32'(speed), 3);
      chk("ramp_f17_qx", 32'(qx), 337);
      chk("ramp_qy", 32'(qy), 230);

      // Opposing keys cancel and reset the ramp
      repeat (3) run_frame(K_LR);
      chk("lr_qx", 32'(qx), 337);
      chk("lr_speed", 32'(speed), 1);
      run_frame(K_RIGHT);
      chk("lr_after_speed", 32'(speed), 1);
      chk("lr_after_qx", 32'(qx), 338);

      // Right edge: ramp to speed 4 and approach 617, then cross
      repeat (23) run_frame(K_RIGHT);
      chk("edge_ramp_qx", 32'(qx), 385);
      repeat (58) run_frame(K_RIGHT);
      chk("edge_speed", 32'(speed), 4);
      chk("edge_pre_qx", 32'(qx), 617);
      run_frame(K_RIGHT);
`ifdef SPRITE_WRAP_EN
      chk("edge_right_qx", 32'(qx), 0);
`else
      chk("edge_right_qx", 32'(qx), 620);
`endif
      run_frame(K_RIGHT);
`ifdef SPRITE_WRAP_EN
      chk("edge_right2_qx", 32'(qx), 4);
`else
      chk("edge_right2_qx", 32'(qx), 620);
`endif
      // Top edge at speed 4: 230 -> 2, then crossing 0
      repeat (57) run_frame(K_UP);
      chk("edge_up_pre_qy", 32'(qy), 2);
      run_frame(K_UP);
`ifdef SPRITE_WRAP_EN
      chk("edge_up_qy", 32'(qy), 460);
`else
      chk("edge_up_qy", 32'(qy), 0);
`endif

      // Auto mode after 120 key-free frames, bounce off bottom and right
      rst_pix = 1'b1;
      tick();
      rst_pix = 1'b0;
      tick();
      repeat (119) run_frame(K_NONE);
      chk("auto_119", 32'(auto_mode), 0);
      chk("auto_119_qx", 32'(qx), 310);
      run_frame(K_NONE);
      chk("auto_120", 32'(auto_mode), 1);
      chk("auto_120_qx", 32'(qx), 311);
      chk("auto_120_qy", 32'(qy), 231);
      chk("auto_speed", 32'(speed), 1);
      repeat (229) run_frame(K_NONE);
      chk("auto_k229_qx", 32'(qx), 540);
      chk("auto_k229_qy", 32'(qy), 460);
      run_frame(K_NONE);
      chk("auto_k230_qy", 32'(qy), 460);
      run_frame(K_NONE);
      chk("auto_k231_qy", 32'(qy), 459);
      chk("auto_k231_qx", 32'(qx), 542);
      repeat (78) run_frame(K_NONE);
      chk("auto_k309_qx", 32'(qx), 620);
      chk("auto_k309_qy", 32'(qy), 381);
      run_frame(K_NONE);
      chk("auto_k310_qx", 32'(qx), 620);
      run_frame(K_NONE);
      chk("auto_k311_qx", 32'(qx), 619);
      chk("auto_k311_qy", 32'(qy), 379);
      run_frame(K_UP);
      chk("auto_exit", 32'(auto_mode), 0);
      chk("auto_exit_qy", 32'(qy), 378);
      chk("auto_exit_qx", 32'(qx), 619);
      chk("auto_exit_speed", 32'(speed), 1);

      // Overrun: second strobe two cycles after the first is ignored
      set_keys(K_RIGHT);
      tick();
      set_keys(K_NONE);
      frame = 1'b1;
      tick();                       // t+1
      frame = 1'b0;
      tick();                       // t+2
      frame = 1'b1;
      tick();                       // t+3
      frame = 1'b0;
      chk("ovr_set", 32'(overrun), 1);
      upd_cnt = 0;
      for (int i = 0; i < 12; i++) begin
         if (upd_done) upd_cnt++;
         tick();
      end
      chk("ovr_upd_count", 32'(upd_cnt), 1);
      chk("ovr_qx", 32'(qx), 620);
      run_frame(K_NONE);
      chk("ovr_sticky", 32'(overrun), 1);
      chk("ovr_qx2", 32'(qx), 620);

      // Reset asserted during MOVE_X
      set_keys(K_LEFT);
      tick();
      set_keys(K_NONE);
      frame = 1'b1;
      tick();                       // t+1 LATCH
      frame = 1'b0;
      tick();                       // t+2 MOVE_X
      rst_pix = 1'b1;
      #1;
      chk("mrst_qx", 32'(qx), 310);
      chk("mrst_qy", 32'(qy), 230);
      chk("mrst_overrun", 32'(overrun), 0);
      chk("mrst_speed", 32'(speed), 1);
      chk("mrst_auto", 32'(auto_mode), 0);
      tick();
      rst_pix = 1'b0;
      upd_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         if (upd_done) upd_cnt++;
         tick();
      end
      chk("mrst_no_upd", 32'(upd_cnt), 0);
      chk("mrst_qx_hold", 32'(qx), 310);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sprite_motion_ctrl.md
Name: sprite_motion_ctrl

Overview:
- Per-frame motion sequencer for the on-screen square sprite.
- Accumulates keyboard direction requests across a frame and applies them at the frame strobe through a multi-cycle FSM.
- Provides speed ramping while a key is held, edge clamping, and an autonomous bounce mode after a period with no input.
- Drives sprite position (qx, qy) into the paint/compare logic of the display top level.

Parameters:
- CORDW, 10, coordinate width.
- H_RES, 640, active horizontal pixels.
- V_RES, 480, active vertical pixels.
- Q_SIZE, 20, sprite edge length in pixels.
- SPEED_MIN, 1, base speed, px/frame.
- SPEED_MAX, 4, ramp ceiling, px/frame.
- RAMP_FRAMES, 8, consecutive held frames per +1 speed step.
- IDLE_FRAMES, 120, key-free frames before entering auto mode.

Ports:
- clk_pix  in  1  pixel clock.
- rst_pix  in  1  reset; asynchronous, active-high.
- frame  in  1  one-cycle strobe at start of vertical blanking.
- key_up / key_down / key_left / key_right  in  1 each  direction requests.
- qx  out  CORDW  sprite left edge.
- qy  out  CORDW  sprite top edge.
- speed  out  3  current speed, px/frame.
- auto_mode  out  1  1 = autonomous bounce.
- upd_done  out  1  one-cycle pulse when qx/qy are final for this frame.
- overrun  out  1  sticky; frame seen while FSM not IDLE.

Behaviour:
- Reset values (asynchronous on rst_pix): qx=(H_RES-Q_SIZE)/2 (310), qy=(V_RES-Q_SIZE)/2 (230), speed=SPEED_MIN, auto_mode=0, upd_done=0, overrun=0, FSM=IDLE, all counters and key latches 0, bounce direction right/down.
- Reset mid-sequence aborts the update. No partial qx/qy change is retained beyond the reset values.
- Key latches: each key_* is OR-accumulated every cycle into a sticky bit. Latches are snapshotted and cleared in LATCH. A key asserted in the LATCH cycle itself lands in the next frame's latch.
- FSM states: IDLE -> LATCH -> MOVE_X -> MOVE_Y -> DONE -> IDLE, one cycle each except IDLE.
  - IDLE: leave on frame=1.
  - LATCH: snapshot keys; update hold/idle counters, speed and mode.
  - MOVE_X: register qx.
  - MOVE_Y: register qy.
  - DONE: upd_done=1.
- Latency: frame high in cycle t gives qx valid from t+3, qy valid from t+4, upd_done high in cycle t+4 only.
- frame=1 in any state other than IDLE: overrun is set and stays set until reset; the strobe is ignored.
- Axis resolution: left and right both latched gives no X motion; the same rule applies to up/down on Y. An axis counts as active only with exactly one direction latched.
- Ramp:
  - If any axis is active, hold_cnt increments, saturating at (SPEED_MAX-SPEED_MIN)*RAMP_FRAMES. Otherwise hold_cnt resets to 0.
  - speed = min(SPEED_MIN + hold_cnt/RAMP_FRAMES, SPEED_MAX), computed in LATCH and used in the same frame.
- Idle/auto:
  - No axis active: idle_cnt increments, saturating at IDLE_FRAMES; any active axis clears it.
  - auto_mode is set in the LATCH where idle_cnt reaches IDLE_FRAMES.
  - Any active axis clears auto_mode in that same LATCH, and the key motion applies that frame.
- Manual motion (arithmetic at CORDW+1 bits, no wrap):
  - Right: if qx+Q_SIZE+speed <= H_RES, qx += speed; else qx = H_RES-Q_SIZE.
  - Left: if qx >= speed, qx -= speed; else qx = 0.
  - Y axis: same rules using V_RES.
- Auto motion:
  - Speed forced to SPEED_MIN; moves along the stored direction bits each frame.
  - If the move would cross a limit, the coordinate clamps to the limit and that axis's direction bit flips in the same cycle.
- Outputs qx, qy, speed, auto_mode, upd_done and overrun are registered.

Optional Feature:
- Macro: SPRITE_WRAP_EN.
- Defined: in manual mode, any case where the clamp would apply instead wraps to the opposite limit: right/down goes to 0, left/up goes to H_RES-Q_SIZE or V_RES-Q_SIZE. Auto mode is unchanged.
- Undefined: clamp behaviour as specified above.

Test Plan:
- Reset, then frame with no keys -> qx=310, qy=230, upd_done exactly 4 cycles after frame, speed=1.
- key_right held for 17 frames from qx=310 -> speed steps 1,1..(8 frames),2..(8),3; qx = 310+8*1+8*2+1*3 = 337.
- qx=619, key_right held, speed 2 -> qx clamps to 620. With SPRITE_WRAP_EN -> qx=0.
- key_left and key_right both held for 3 frames -> qx unchanged, speed stays 1, hold_cnt stays 0.
- 120 key-free frames -> auto_mode=1 at the 120th LATCH, sprite moves +1/+1 per frame and reflects at qx=620. A key_up pulse mid-frame -> auto_mode=0 at the next LATCH, and qy decrements by 1.
- frame pulsed twice 2 cycles apart -> overrun=1 (sticky), second update not performed. Assert rst_pix in the MOVE_X cycle -> outputs return to reset values immediately.
